// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : eth_tx_arbiter_if
// Brief    : AXI-Stream bundle: N requester slices in, one MAC FIFO TX port out.
// Revision : 1.0
// =============================================================================
interface eth_tx_arbiter_if #(
    parameter int N_PORTS = 4
);
    logic [N_PORTS*64-1:0] s_axis_tdata;
    logic [N_PORTS*8-1:0]  s_axis_tkeep;
    logic [N_PORTS-1:0]    s_axis_tvalid;
    logic [N_PORTS-1:0]    s_axis_tlast;
    logic [N_PORTS-1:0]    s_axis_tuser;
    logic [N_PORTS-1:0]    s_axis_tready;

    logic [63:0]           m_axis_tdata;
    logic [7:0]            m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  m_axis_tready;

    // Environment side: requesters drive s_axis_*, the MAC FIFO drives tready.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );

    // Arbiter side.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : eth_tx_arbiter
// Brief    : Round-robin frame arbiter into a 10G MAC TX FIFO with idle abort.
// Revision : 1.0
// =============================================================================
module eth_tx_arbiter #(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire             clock,
    input  wire             resetn,
    eth_tx_arbiter_if.slave axis,
    output logic [1:0]      grant_idx,
    output logic            busy,
    output logic [15:0]     abort_count
);

    localparam logic [1:0]  c_grant_rst = 2'(N_PORTS - 1);
    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_ABORT = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [63:0] data_q,  data_d;
    logic [7:0]  keep_q,  keep_d;
    logic        vld_q,   vld_d;
    logic        last_q,  last_d;
    logic        user_q,  user_d;
    logic [15:0] idle_q,  idle_d;
    logic [15:0] abort_q, abort_d;

    logic [63:0]        w_sel_data;
    logic [7:0]         w_sel_keep;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;
    logic [N_PORTS-1:0] w_grant_oh;
    logic [N_PORTS-1:0] w_tready;
    logic [1:0]         w_next_grant;
    logic               w_any_valid;
    logic               w_slot_free;
    logic [15:0]        w_idle_inc;

    assign w_slot_free = !vld_q || axis.m_axis_tready;
    assign w_any_valid = |axis.s_axis_tvalid;
    assign w_idle_inc  = idle_q + 16'd1;

    // Mux the granted requester's slice.
    always_comb begin
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_user  = 1'b0;
        w_grant_oh  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == 2'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_sel_data    = axis.s_axis_tdata[i*64 +: 64];
                w_sel_keep    = axis.s_axis_tkeep[i*8 +: 8];
                w_sel_valid   = axis.s_axis_tvalid[i];
                w_sel_last    = axis.s_axis_tlast[i];
                w_sel_user    = axis.s_axis_tuser[i];
            end
        end
    end

    // Offsets are walked farthest-first so the nearest requester after the last grant wins.
    always_comb begin
        w_next_grant = grant_q;
        for (int off = N_PORTS; off >= 1; off--) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (axis.s_axis_tvalid[i] &&
                    ((int'(grant_q) + off == i) || (int'(grant_q) + off == i + N_PORTS))) begin
                    w_next_grant = 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        user_d   = user_q;
        vld_d    = vld_q && !axis.m_axis_tready;
        idle_d   = idle_q;
        abort_d  = abort_q;
        w_tready = '0;

        case (state_q)
            S_IDLE: begin
                if (w_any_valid) begin
                    grant_d = w_next_grant;
                    idle_d  = '0;
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                w_tready = w_slot_free ? w_grant_oh : '0;
                if (w_sel_valid && w_slot_free) begin
                    data_d = w_sel_data;
                    keep_d = w_sel_keep;
                    last_d = w_sel_last;
                    user_d = w_sel_user;
                    vld_d  = 1'b1;
                    idle_d = '0;
                    if (w_sel_last) begin
                        state_d = S_IDLE;
                    end
                end else if (w_slot_free) begin
                    // Backpressure from the MAC never counts as requester idle time.
                    idle_d = w_idle_inc;
                    if (w_idle_inc == c_timeout) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                if (w_slot_free) begin
                    data_d  = '0;
                    keep_d  = 8'h01;
                    last_d  = 1'b1;
                    user_d  = 1'b1;
                    vld_d   = 1'b1;
                    abort_d = abort_q + 16'd1;
                    idle_d  = '0;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                w_tready = w_grant_oh;
                if (w_sel_valid && w_sel_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= c_grant_rst;
            data_q  <= '0;
            keep_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            idle_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            user_q  <= user_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
        end
    end

    assign axis.s_axis_tready = w_tready;
    assign axis.m_axis_tdata  = data_q;
    assign axis.m_axis_tkeep  = keep_q;
    assign axis.m_axis_tvalid = vld_q;
    assign axis.m_axis_tlast  = last_q;
    assign axis.m_axis_tuser  = user_q;
    assign grant_idx          = grant_q;
    assign busy               = (state_q != S_IDLE);
    assign abort_count        = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_eth_tx_arbiter
// Brief    : Directed self-checking bench for eth_tx_arbiter (4 ports, TIMEOUT=16).
// Revision : 1.0
// =============================================================================
module tb_eth_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [15:0] abort_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    eth_tx_arbiter_if #(.N_PORTS(N)) axis ();

    eth_tx_arbiter #(
        .N_PORTS (N),
        .TIMEOUT (TO)
    ) dut (
        .clock       (clk),
        .resetn      (resetn),
        .axis        (axis),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .abort_count (abort_count)
    );

    task automatic drive(input logic [1:0] p, input logic v, input logic [63:0] d,
                         input logic [7:0] k, input logic l, input logic u);
        axis.s_axis_tvalid[p]              = v;
        axis.s_axis_tdata[{p, 6'd0} +: 64] = d;
        axis.s_axis_tkeep[{p, 3'd0} +: 8]  = k;
        axis.s_axis_tlast[p]               = l;
        axis.s_axis_tuser[p]               = u;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%0h exp=0", axis.m_axis_tvalid); end
        checks++; if (axis.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%0h exp=0", axis.m_axis_tlast); end
        checks++; if (axis.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got=%0h exp=0", axis.m_axis_tuser); end
        checks++; if (axis.m_axis_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", axis.m_axis_tdata); end
        checks++; if (axis.m_axis_tkeep !== 8'h00) begin errors++; $display("FAIL rst_tkeep got=%h exp=00", axis.m_axis_tkeep); end
        checks++; if (axis.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rst_sready got=%b exp=0000", axis.s_axis_tready); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL rst_grant got=%0d exp=3", grant_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL rst_abort got=%0d exp=0", abort_count); end
        resetn = 1'b1;
    endtask

    task automatic test_two_ports();
        @(negedge clk);
        drive(2'd0, 1'b1, 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        drive(2'd2, 1'b1, 64'hC0C0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL tp_grant0 got=%0d exp=0", grant_idx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tp_busy0 got=%0h exp=1", busy); end
        checks++; if (axis.s_axis_tready !== 4'b0001) begin errors++; $display("FAIL tp_sready0 got=%b exp=0001", axis.s_axis_tready); end
        checks++; if (axis.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tp_mvalid0 got=%0h exp=0", axis.m_axis_tvalid); end
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL tp_a0_valid got=%0h exp=1", axis.m_axis_tvalid); end
        checks++; if (axis.m_axis_tdata !== 64'hA0A0_0000_0000_0001) begin errors++; $display("FAIL tp_a0_data got=%h exp=a0a0000000000001", axis.m_axis_tdata); end
        drive(2'd0, 1'b1, 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hA0A0_0000_0000_0002) begin errors++; $display("FAIL tp_a1_data got=%h exp=a0a0000000000002", axis.m_axis_tdata); end
        drive(2'd0, 1'b1, 64'hA0A0_0000_0000_0003, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hA0A0_0000_0000_0003) begin errors++; $display("FAIL tp_a2_data got=%h exp=a0a0000000000003", axis.m_axis_tdata); end
        checks++; if (axis.m_axis_tkeep !== 8'h0F) begin errors++; $display("FAIL tp_a2_keep got=%h exp=0f", axis.m_axis_tkeep); end
        checks++; if (axis.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL tp_a2_last got=%0h exp=1", axis.m_axis_tlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tp_idle_busy got=%0h exp=0", busy); end
        checks++; if (axis.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL tp_idle_sready got=%b exp=0000", axis.s_axis_tready); end
        drive(2'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL tp_grant2 got=%0d exp=2", grant_idx); end
        checks++; if (axis.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tp_gap_valid got=%0h exp=0", axis.m_axis_tvalid); end
        checks++; if (axis.s_axis_tready !== 4'b0100) begin errors++; $display("FAIL tp_sready2 got=%b exp=0100", axis.s_axis_tready); end
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hC0C0_0000_0000_0001) begin errors++; $display("FAIL tp_c0_data got=%h exp=c0c0000000000001", axis.m_axis_tdata); end
        drive(2'd2, 1'b1, 64'hC0C0_0000_0000_0002, 8'h3F, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hC0C0_0000_0000_0002) begin errors++; $display("FAIL tp_c1_data got=%h exp=c0c0000000000002", axis.m_axis_tdata); end
        checks++; if (axis.m_axis_tkeep !== 8'h3F) begin errors++; $display("FAIL tp_c1_keep got=%h exp=3f", axis.m_axis_tkeep); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tp_c1_busy got=%0h exp=0", busy); end
        drive(2'd2, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int p = 0; p < N; p++) drive(2'(p), 1'b1, 64'h100 + 64'(p), 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (grant_idx !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant_idx, k % 4); end
            checks++; if (busy !== 1'b1 || axis.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rr_gap k=%0d busy=%0h mvalid=%0h exp busy=1 mvalid=0", k, busy, axis.m_axis_tvalid); end
            @(negedge clk);
            checks++; if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 64'h100 + 64'(k % 4)) begin errors++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, axis.m_axis_tdata, 64'h100 + 64'(k % 4)); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle k=%0d got=%0h exp=0", k, busy); end
        end
        for (int p = 0; p < N; p++) drive(2'(p), 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive(2'd1, 1'b1, 64'hB0B0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL bp_grant got=%0d exp=1", grant_idx); end
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hB0B0_0000_0000_0001) begin errors++; $display("FAIL bp_b0 got=%h exp=b0b0000000000001", axis.m_axis_tdata); end
        drive(2'd1, 1'b1, 64'hB0B0_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        axis.m_axis_tready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++; if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 64'hB0B0_0000_0000_0001) begin errors++; $display("FAIL bp_hold i=%0d valid=%0h data=%h exp valid=1 data=b0b0000000000001", i, axis.m_axis_tvalid, axis.m_axis_tdata); end
            checks++; if (axis.s_axis_tready !== 4'b0000 || abort_count !== 16'd0) begin errors++; $display("FAIL bp_stall i=%0d sready=%b abort=%0d exp 0000/0", i, axis.s_axis_tready, abort_count); end
        end
        axis.m_axis_tready = 1'b1;
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hB0B0_0000_0000_0002) begin errors++; $display("FAIL bp_b1 got=%h exp=b0b0000000000002", axis.m_axis_tdata); end
        drive(2'd1, 1'b1, 64'hB0B0_0000_0000_0003, 8'h07, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hB0B0_0000_0000_0003 || axis.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL bp_b2 data=%h last=%0h exp b0b0000000000003/1", axis.m_axis_tdata, axis.m_axis_tlast); end
        checks++; if (abort_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end abort=%0d busy=%0h exp 0/0", abort_count, busy); end
        drive(2'd1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        drive(2'd1, 1'b1, 64'hD0D0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL to_grant got=%0d exp=1", grant_idx); end
        @(negedge clk);
        drive(2'd1, 1'b1, 64'hD0D0_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'hD0D0_0000_0000_0002) begin errors++; $display("FAIL to_d1 got=%h exp=d0d0000000000002", axis.m_axis_tdata); end
        drive(2'd1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            checks++; if (axis.m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait i=%0d mvalid=%0h busy=%0h exp 0/1", i, axis.m_axis_tvalid, busy); end
        end
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 64'h0) begin errors++; $display("FAIL to_abort_beat valid=%0h data=%h exp 1/0", axis.m_axis_tvalid, axis.m_axis_tdata); end
        checks++; if (axis.m_axis_tkeep !== 8'h01 || axis.m_axis_tlast !== 1'b1 || axis.m_axis_tuser !== 1'b1) begin errors++; $display("FAIL to_abort_flags keep=%h last=%0h user=%0h exp 01/1/1", axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tuser); end
        checks++; if (abort_count !== 16'd1) begin errors++; $display("FAIL to_count got=%0d exp=1", abort_count); end
        checks++; if (axis.s_axis_tready !== 4'b0010) begin errors++; $display("FAIL to_drop_ready got=%b exp=0010", axis.s_axis_tready); end
        drive(2'd1, 1'b1, 64'hD0D0_0000_0000_0003, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b0 || axis.s_axis_tready !== 4'b0010) begin errors++; $display("FAIL to_drop1 mvalid=%0h sready=%b exp 0/0010", axis.m_axis_tvalid, axis.s_axis_tready); end
        drive(2'd1, 1'b1, 64'hD0D0_0000_0000_0004, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_drop_end mvalid=%0h busy=%0h exp 0/0", axis.m_axis_tvalid, busy); end
        drive(2'd1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_edge();
        @(negedge clk);
        drive(2'd3, 1'b1, 64'hE0E0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL te_grant got=%0d exp=3", grant_idx); end
        @(negedge clk);
        drive(2'd3, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            checks++; if (axis.m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL te_wait i=%0d mvalid=%0h busy=%0h exp 0/1", i, axis.m_axis_tvalid, busy); end
        end
        drive(2'd3, 1'b1, 64'hE0E0_0000_0000_0002, 8'h1F, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 64'hE0E0_0000_0000_0002) begin errors++; $display("FAIL te_beat valid=%0h data=%h exp 1/e0e0000000000002", axis.m_axis_tvalid, axis.m_axis_tdata); end
        checks++; if (axis.m_axis_tkeep !== 8'h1F || axis.m_axis_tuser !== 1'b1 || axis.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL te_flags keep=%h user=%0h last=%0h exp 1f/1/1", axis.m_axis_tkeep, axis.m_axis_tuser, axis.m_axis_tlast); end
        checks++; if (abort_count !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL te_noabort abort=%0d busy=%0h exp 1/0", abort_count, busy); end
        drive(2'd3, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(2'd2, 1'b1, 64'hF0F0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL ar_grant got=%0d exp=2", grant_idx); end
        @(negedge clk);
        checks++; if (axis.m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_inflight mvalid=%0h busy=%0h exp 1/1", axis.m_axis_tvalid, busy); end
        drive(2'd2, 1'b1, 64'hF0F0_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checks++; if (axis.m_axis_tvalid !== 1'b0 || axis.m_axis_tdata !== 64'h0 || axis.m_axis_tkeep !== 8'h00) begin errors++; $display("FAIL ar_mout valid=%0h data=%h keep=%h exp 0/0/00", axis.m_axis_tvalid, axis.m_axis_tdata, axis.m_axis_tkeep); end
        checks++; if (axis.m_axis_tlast !== 1'b0 || axis.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL ar_mflags last=%0h user=%0h exp 0/0", axis.m_axis_tlast, axis.m_axis_tuser); end
        checks++; if (axis.s_axis_tready !== 4'b0000 || grant_idx !== 2'd3) begin errors++; $display("FAIL ar_grant_rst sready=%b grant=%0d exp 0000/3", axis.s_axis_tready, grant_idx); end
        checks++; if (busy !== 1'b0 || abort_count !== 16'd0) begin errors++; $display("FAIL ar_status busy=%0h abort=%0d exp 0/0", busy, abort_count); end
        drive(2'd0, 1'b1, 64'h6060_0000_0000_0001, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (grant_idx !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL ar_regrant grant=%0d busy=%0h exp 0/1", grant_idx, busy); end
        @(negedge clk);
        checks++; if (axis.m_axis_tdata !== 64'h6060_0000_0000_0001 || axis.m_axis_tlast !== 1'b1) begin errors++; $display("FAIL ar_g0 data=%h last=%0h exp 6060000000000001/1", axis.m_axis_tdata, axis.m_axis_tlast); end
        drive(2'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        drive(2'd2, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        axis.s_axis_tdata  = '0;
        axis.s_axis_tkeep  = '0;
        axis.s_axis_tvalid = '0;
        axis.s_axis_tlast  = '0;
        axis.s_axis_tuser  = '0;
        axis.m_axis_tready = 1'b1;
        test_reset();
        test_two_ports();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_timeout_edge();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
